// File: rtl/alarm_scheduler.sv
// Multi-channel alarm controller: N enabled alarm compares feed a ring/snooze
// FSM that drives a registered alarm output from the divided clock.
module alarm_scheduler #(
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 5,
    parameter int SNOOZE_SEC = 300,
    parameter int SNOOZE_MAX = 3,
    localparam int ID_W      = $clog2(N_ALARM),
    localparam int SC_W      = (SNOOZE_MAX > 0) ? $clog2(SNOOZE_MAX + 1) : 1
) (
    input  logic                   clk_ac,
    input  logic                   reset,
    input  logic                   sec_tick,
    input  logic [17:0]            clock_inp,
    input  logic [18*N_ALARM-1:0]  alarm_inp,
    input  logic [N_ALARM-1:0]     alarm_en,
    input  logic                   snooze,
    input  logic                   stop,
    output logic                   ot_ac,
    output logic [1:0]             state,
    output logic [ID_W-1:0]        active_id,
    output logic [SC_W-1:0]        snooze_cnt
);

    localparam int RC_W = $clog2(RING_SEC + 1);
    localparam int SN_W = $clog2(SNOOZE_SEC + 1);
    localparam logic [RC_W-1:0] RING_LOAD = RC_W'(RING_SEC);
    localparam logic [SN_W-1:0] SNZ_LOAD  = SN_W'(SNOOZE_SEC);
    localparam logic [SC_W-1:0] SC_LIMIT  = SC_W'(SNOOZE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [RC_W-1:0]   ring_cnt, ring_nxt;
    logic [SN_W-1:0]   snz_cnt, snz_nxt;
    logic [ID_W-1:0]   id_nxt, match_id;
    logic [SC_W-1:0]   scnt_nxt;
    logic [N_ALARM-1:0] chan_hit;
    logic              match_any;
    logic              end_event;
    logic              snooze_ok;

    // A channel only hits on a tick, when enabled, and when its time is a legal hh:mm:ss.
    for (genvar g = 0; g < N_ALARM; g++) begin : g_chan
        logic [17:0] at;
        assign at = alarm_inp[18*g +: 18];
        assign chan_hit[g] = sec_tick && alarm_en[g]
                          && (at[17:12] <= 6'd23) && (at[11:6] <= 6'd59) && (at[5:0] <= 6'd59)
                          && (at == clock_inp);
    end

    always_comb begin
        match_any = 1'b0;
        match_id  = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (chan_hit[i]) begin
                match_any = 1'b1;
                match_id  = ID_W'(i);
            end
        end
    end

    assign end_event = stop || !alarm_en[active_id];
    assign snooze_ok = snooze && (snooze_cnt < SC_LIMIT);

    always_ff @(posedge clk_ac or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            active_id  <= '0;
            snooze_cnt <= '0;
            ot_ac      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            ring_cnt   <= ring_nxt;
            snz_cnt    <= snz_nxt;
            active_id  <= id_nxt;
            snooze_cnt <= scnt_nxt;
            ot_ac      <= (state_nxt == RING);
        end
    end

    assign state = state_q;

    // Stop/enable-drop outrank snooze, which outranks the tick countdown.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (match_any) state_nxt = RING;
            end
            RING: begin
                if (end_event)                                state_nxt = IDLE;
                else if (snooze_ok)                           state_nxt = SNOOZE;
                else if (sec_tick && (ring_cnt <= RC_W'(1)))  state_nxt = IDLE;
            end
            SNOOZE: begin
                if (end_event)                                state_nxt = IDLE;
                else if (sec_tick && (snz_cnt <= SN_W'(1)))   state_nxt = RING;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ring_nxt = ring_cnt;
        snz_nxt  = snz_cnt;
        id_nxt   = active_id;
        scnt_nxt = snooze_cnt;
        case (state_q)
            IDLE: begin
                if (state_nxt == RING) begin
                    id_nxt   = match_id;
                    scnt_nxt = '0;
                    ring_nxt = RING_LOAD;
                end
            end
            RING: begin
                if (state_nxt == IDLE) begin
                    scnt_nxt = '0;
                    ring_nxt = '0;
                end else if (state_nxt == SNOOZE) begin
                    scnt_nxt = snooze_cnt + SC_W'(1);
                    snz_nxt  = SNZ_LOAD;
                end else if (sec_tick && (ring_cnt != '0)) begin
                    ring_nxt = ring_cnt - RC_W'(1);
                end
            end
            SNOOZE: begin
                if (state_nxt == IDLE) begin
                    scnt_nxt = '0;
                    snz_nxt  = '0;
                end else if (state_nxt == RING) begin
                    ring_nxt = RING_LOAD;
                    snz_nxt  = '0;
                end else if (sec_tick && (snz_cnt != '0)) begin
                    snz_nxt = snz_cnt - SN_W'(1);
                end
            end
            default: begin
                ring_nxt = '0;
                snz_nxt  = '0;
                scnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-channel alarm controller for the clock design; generalises the single-alarm compare into N independently enabled alarms with a programmable ring length, a snooze with limited retries, and an explicit stop. Sits between the time-keeping counter (hh:mm:ss, 6 bits per field) and the LED/buzzer driver. It is clocked by the divided clock, advances on the time-keeper's one-cycle `sec_tick`, and drives a single registered alarm output.

## Interface

- `N_ALARM`, 4, number of alarm channels (≥2)
- `RING_SEC`, 5, ring duration in seconds (≥1)
- `SNOOZE_SEC`, 300, snooze interval in seconds (≥1)
- `SNOOZE_MAX`, 3, maximum snoozes per alarm event (≥0)

Ports:

- `clk_ac` in 1 — block clock (divided FPGA clock)
- `reset` in 1 — one clock; reset is asynchronous and active-low
- `sec_tick` in 1 — one-cycle pulse, `clock_inp` has just advanced one second
- `clock_inp` in 18 — current time {hour[17:12], min[11:6], sec[5:0]}
- `alarm_inp` in 18*N_ALARM — alarm times; channel i at [18i+17:18i], same field layout
- `alarm_en` in N_ALARM — per-channel enable
- `snooze` in 1 — one-cycle snooze request
- `stop` in 1 — one-cycle stop request
- `ot_ac` out 1 — alarm signal, high while ringing
- `state` out 2 — 0 IDLE, 1 RING, 2 SNOOZE
- `active_id` out $clog2(N_ALARM) — channel owning the current event
- `snooze_cnt` out $clog2(SNOOZE_MAX+1) — snoozes used in current event

## Operation

- Reset (`reset`=0, any time): state IDLE, `ot_ac`=0, `active_id`=0, `snooze_cnt`=0, internal counters 0. Reset mid-RING/SNOOZE abandons the event.
- Match: channel i matches when `alarm_en[i]`=1 and `alarm_inp[i]`==`clock_inp` (full 18-bit equality). Evaluated only in cycles with `sec_tick`=1, so each alarm fires exactly once per occurrence. Channels holding invalid times (field >59 or hour >23) never match.
- Priority: several simultaneous matches → lowest index wins; others dropped.
- IDLE: on match → RING, latch `active_id`, `snooze_cnt`←0, ring counter←RING_SEC.
- RING: `ot_ac`=1. Each `sec_tick` decrements ring counter; tick that brings it to 0 → IDLE (timeout, event ends). `snooze` with `snooze_cnt`<SNOOZE_MAX → SNOOZE, `snooze_cnt`+1, snooze counter←SNOOZE_SEC. `snooze` with `snooze_cnt`==SNOOZE_MAX ignored.
- SNOOZE: `ot_ac`=0. Each `sec_tick` decrements snooze counter; reaching 0 → RING, ring counter←RING_SEC.
- `stop` in RING or SNOOZE → IDLE, `snooze_cnt`←0. `stop` in IDLE ignored.
- `alarm_en[active_id]` deasserted in RING/SNOOZE → IDLE next cycle (same as stop).
- Matches during RING/SNOOZE are ignored and not queued.
- Simultaneous events, priority highest first: reset > stop / enable-drop > snooze > `sec_tick` countdown. E.g. `snooze` and final ring tick in the same cycle → SNOOZE.
- `snooze`/`stop` are sampled only while asserted; held-high inputs act once per cycle (bench drives pulses).
- Counter widths: ring counter $clog2(RING_SEC+1), snooze counter $clog2(SNOOZE_SEC+1); no wrap, they stop at 0.
- Midnight wrap is not special: alarm at 23:59:59 and at 00:00:00 each fire on their own tick; a ring straddling midnight continues normally.

## Timing

- All outputs registered; `ot_ac` derived from next-state, no combinational path input→output.
- Match latency: `ot_ac` rises the cycle after the matching `sec_tick` cycle.
- Ring length: `ot_ac` stays high through exactly RING_SEC `sec_tick`s; falls the cycle after the RING_SEC-th tick after entry (counting starts from the tick after the trigger tick).
- Snooze length: `ot_ac` re-rises the cycle after the SNOOZE_SEC-th tick after the snooze request.
- `snooze`/`stop` take effect the following cycle.

## Test plan

- Reset values: assert `reset`=0 mid-RING → `ot_ac`=0, `state`=0, `snooze_cnt`=0 immediately (async), no ring after release.
- Single alarm: ch1=07:30:00 enabled, clock ticks to 07:30:00 → `ot_ac`=1 next cycle, `active_id`=1, falls after 5 further ticks; disabled channel with same time → no ring.
- Priority: ch0 and ch2 both 12:00:00 → `active_id`=0, one event only.
- Snooze limit (SNOOZE_SEC=3 for sim): snooze ×3 → three re-rings 3 ticks after each, `snooze_cnt`=3; fourth snooze ignored, ring times out after 5 ticks → IDLE.
- Stop/snooze conflict: `stop` and `snooze` same cycle in RING → IDLE, `snooze_cnt`=0; `snooze` on final ring tick → SNOOZE.
- Midnight wrap: ch0=23:59:58, ch1=00:00:00 → ch0 rings across 00:00:00; ch1 match ignored during ring; clearing `alarm_en[0]` → IDLE next cycle.
